// File: rtl/branch_resolution_queue.sv
// rtl/branch_resolution_queue.sv - in-order branch FIFO closing the predictor training loop
module branch_resolution_queue #(
    parameter int DEPTH     = 4,
    parameter int s_history = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_valid,
    input  logic [31:0]          enq_pc,
    input  logic                 enq_pred_taken,
    input  logic [s_history-1:0] enq_ghist,
    input  logic                 res_valid,
    input  logic [31:0]          res_pc,
    input  logic                 res_taken,
    output logic                 full,
    output logic                 upd_valid,
    output logic [31:0]          upd_pc,
    output logic                 upd_mispredict,
    output logic [s_history-1:0] upd_ghist,
    output logic                 flush,
    output logic [s_history-1:0] restore_ghist,
    output logic                 order_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]          pc_mem   [DEPTH];
    logic                 pred_mem [DEPTH];
    logic [s_history-1:0] gh_mem   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic can_enq;
    logic has_head;
    logic res_pop;
    logic pc_match;
    logic is_mis;
    logic kill;

    // full is a pure function of the pre-edge occupancy, so a same-cycle pop never frees a slot
    assign full = (count == CW'(DEPTH));

    // decode this cycle's enqueue / resolve against the oldest entry
    always_comb begin
        can_enq  = enq_valid && !full;
        has_head = (count != '0);
        res_pop  = res_valid && has_head;
        pc_match = (res_pc == pc_mem[head]);
        is_mis   = (pred_mem[head] != res_taken);
        // a mispredict or an out-of-order resolve squashes every younger entry
        kill     = res_pop && (!pc_match || is_mis);
    end

    // entry payload storage; contents are don't-care until validated by count
    always_ff @(posedge clk) begin
        if (can_enq) begin
            pc_mem[tail]   <= enq_pc;
            pred_mem[tail] <= enq_pred_taken;
            gh_mem[tail]   <= enq_ghist;
        end
    end

    // pointers, occupancy and the registered predictor update / flush bundle
    always_ff @(posedge clk) begin
        if (!rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_mispredict <= 1'b0;
            upd_ghist      <= '0;
            flush          <= 1'b0;
            restore_ghist  <= '0;
            order_err      <= 1'b0;
        end else begin
            upd_valid      <= 1'b0;
            upd_mispredict <= 1'b0;
            flush          <= 1'b0;

            if (res_valid && !has_head) begin
                order_err <= 1'b1;
            end

            if (res_pop && !pc_match) begin
                order_err <= 1'b1;
            end

            if (res_pop && pc_match) begin
                upd_valid      <= 1'b1;
                upd_pc         <= pc_mem[head];
                upd_ghist      <= gh_mem[head];
                upd_mispredict <= is_mis;
            end

            if (kill) begin
                flush         <= 1'b1;
                restore_ghist <= {gh_mem[head][s_history-2:0], res_taken};
                head          <= tail;
                count         <= '0;
            end else begin
                if (res_pop) begin
                    head <= head + PW'(1);
                end
                if (can_enq) begin
                    tail <= tail + PW'(1);
                end
                count <= count + CW'(can_enq) - CW'(res_pop);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// tb/tb_branch_resolution_queue.sv - randomized and directed bench with queue reference model
module tb_branch_resolution_queue;

    localparam int DEPTH = 4;
    localparam int SH    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enq_valid = 1'b0;
    logic [31:0]   enq_pc = '0;
    logic          enq_pred_taken = 1'b0;
    logic [SH-1:0] enq_ghist = '0;
    logic          res_valid = 1'b0;
    logic [31:0]   res_pc = '0;
    logic          res_taken = 1'b0;
    logic          full;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_mispredict;
    logic [SH-1:0] upd_ghist;
    logic          flush;
    logic [SH-1:0] restore_ghist;
    logic          order_err;

    branch_resolution_queue #(.DEPTH(DEPTH), .s_history(SH)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken), .enq_ghist(enq_ghist),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .full(full), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_mispredict(upd_mispredict),
        .upd_ghist(upd_ghist), .flush(flush), .restore_ghist(restore_ghist), .order_err(order_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic          pred;
        logic [SH-1:0] gh;
    } entry_t;

    entry_t q[$];
    int     vectors = 0;
    int     n_checks = 0;
    int     fails = 0;

    logic          e_valid, e_mis, e_flush, e_err;
    logic [31:0]   e_pc;
    logic [SH-1:0] e_gh, e_restore;
    logic          was_reset;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ev, input logic [31:0] epc, input logic ep,
                        input logic [SH-1:0] eg, input logic rv, input logic [31:0] rpc, input logic rt);
        entry_t h;
        bit room;
        rst = r; enq_valid = ev; enq_pc = epc; enq_pred_taken = ep; enq_ghist = eg;
        res_valid = rv; res_pc = rpc; res_taken = rt;
        #1;
        chk("full_pre", full, q.size() == DEPTH);
        room = (q.size() < DEPTH);
        e_valid = 1'b0; e_mis = 1'b0; e_flush = 1'b0; was_reset = 1'b0;
        if (!r) begin
            q.delete();
            e_pc = '0; e_gh = '0; e_restore = '0; e_err = 1'b0; was_reset = 1'b1;
        end else if (rv && q.size() == 0) begin
            e_err = 1'b1;
            if (ev && room) q.push_back('{epc, ep, eg});
        end else if (rv) begin
            h = q[0];
            if (rpc != h.pc) begin
                e_err = 1'b1; e_flush = 1'b1;
                e_restore = SH'(({25'd0, h.gh} << 1) | rt);
                q.delete();
            end else begin
                e_valid = 1'b1; e_pc = h.pc; e_gh = h.gh; e_mis = (h.pred != rt);
                if (e_mis) begin
                    e_flush = 1'b1;
                    e_restore = SH'(({25'd0, h.gh} << 1) | rt);
                    q.delete();
                end else begin
                    void'(q.pop_front());
                    if (ev && room) q.push_back('{epc, ep, eg});
                end
            end
        end else if (ev && room) begin
            q.push_back('{epc, ep, eg});
        end
        @(posedge clk);
        #1;
        vectors++;
        chk("upd_valid", upd_valid, e_valid);
        chk("flush", flush, e_flush);
        chk("order_err", order_err, e_err);
        chk("upd_mispredict", upd_mispredict, e_mis);
        chk("full_post", full, q.size() == DEPTH);
        if (e_valid || was_reset) begin
            chk("upd_pc", upd_pc, e_pc);
            chk("upd_ghist", upd_ghist, e_gh);
        end
        if (e_flush || was_reset) chk("restore_ghist", restore_ghist, e_restore);
    endtask

    task automatic enq(input logic [31:0] pc, input logic p, input logic [SH-1:0] g);
        step(1'b1, 1'b1, pc, p, g, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic res(input logic [31:0] pc, input logic t);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b1, pc, t);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        e_err = 1'b0; e_pc = '0; e_gh = '0; e_restore = '0;
        do_reset();

        // correct resolve of the oldest entry
        enq(32'h100, 1'b1, 7'h05);
        enq(32'h104, 1'b0, 7'h0A);
        res(32'h100, 1'b1);
        chk("tp1_pc", upd_pc, 32'h100);
        chk("tp1_gh", upd_ghist, 32'h05);
        chk("tp1_left", q.size(), 32'd1);

        // mispredict flushes the queue; a following resolve is an order error
        do_reset();
        enq(32'h100, 1'b1, 7'h05);
        enq(32'h104, 1'b0, 7'h0A);
        res(32'h100, 1'b0);
        chk("tp2_mis", upd_mispredict, 32'd1);
        chk("tp2_restore", restore_ghist, 32'h0A);
        res(32'h104, 1'b0);
        chk("tp2_err", order_err, 32'd1);

        // fill, overflow drop, back-to-back drain, wrap-around
        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h200 + 32'(4 * i), 1'b1, SH'(i + 1));
        chk("tp3_full", full, 32'd1);
        enq(32'h300, 1'b1, 7'h33);
        for (int i = 0; i < 4; i++) begin
            res(32'h200 + 32'(4 * i), 1'b1);
            chk("tp3_fifo_pc", upd_pc, 32'h200 + 32'(4 * i));
        end
        for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), 1'(i), SH'(i + 9));
        for (int i = 0; i < 4; i++) res(32'h400 + 32'(4 * i), 1'(i));

        // enq + correct resolve while full drops the enqueue
        for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4 * i), 1'b0, SH'(i));
        step(1'b1, 1'b1, 32'h5F0, 1'b1, 7'h7F, 1'b1, 32'h500, 1'b0);
        chk("tp4_notfull", full, 32'd0);
        chk("tp4_count", q.size(), 32'd3);
        // enq + mispredict discards the enqueue
        step(1'b1, 1'b1, 32'h5F4, 1'b1, 7'h7E, 1'b1, 32'h504, 1'b1);
        chk("tp4_empty", q.size(), 32'd0);

        // out-of-order resolve is sticky until reset
        do_reset();
        enq(32'h100, 1'b1, 7'h05);
        res(32'h200, 1'b1);
        chk("tp5_noupd", upd_valid, 32'd0);
        chk("tp5_flush", flush, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0, 32'h0, 1'b0);
        chk("tp5_sticky", order_err, 32'd1);

        // reset wins over pending resolve with entries in flight
        do_reset();
        for (int i = 0; i < 3; i++) enq(32'h600 + 32'(4 * i), 1'b1, SH'(i));
        step(1'b0, 1'b1, 32'h700, 1'b1, 7'h11, 1'b1, 32'h600, 1'b0);
        chk("tp6_err", order_err, 32'd0);
        chk("tp6_full", full, 32'd0);

        // randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic          r, ev, ep, rv, rt;
            logic [31:0]   epc, rpc;
            logic [SH-1:0] eg;
            r   = ($urandom_range(0, 49) != 0);
            ev  = ($urandom_range(0, 9) < 6);
            epc = {$urandom_range(0, 255), 2'b00};
            ep  = 1'($urandom);
            eg  = SH'($urandom);
            rv  = ($urandom_range(0, 9) < 5) && (q.size() > 0 || $urandom_range(0, 19) == 0);
            rpc = (q.size() > 0) ? q[0].pc : 32'($urandom);
            if ($urandom_range(0, 29) == 0) rpc = rpc ^ 32'h4;
            rt  = (q.size() > 0 && $urandom_range(0, 9) < 8) ? q[0].pred : 1'($urandom);
            step(r, ev, epc, ep, eg, rv, rpc, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/branch_resolution_queue.md
Name: branch_resolution_queue

Overview:
- Sits between the fetch-side direction predictor and the execute stage, and closes the predictor's training loop.
- In-order FIFO. Each entry records one fetched control-flow instruction: its PC, predicted direction and global-history snapshot.
- When EX resolves the oldest entry, the block produces the registered update bundle the predictor consumes (update enable, resolved PC, mispredict flag, resolved history).
- On a mispredict it also produces a flush pulse and the repaired global history.

Parameters:
- DEPTH, 4, number of in-flight branch entries (power of 2, ≥2).
- s_history, 7, width of the global-history snapshot.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- enq_valid  input  1  IF holds a br/jal/jalr and advances this cycle.
- enq_pc  input  32  PC of the enqueued instruction.
- enq_pred_taken  input  1  predicted direction (1 = taken).
- enq_ghist  input  s_history  global history at prediction time.
- res_valid  input  1  EX resolves the oldest in-flight branch this cycle.
- res_pc  input  32  PC of the resolving instruction.
- res_taken  input  1  actual direction.
- full  output  1  combinational; count == DEPTH; fetch must stall.
- upd_valid  output  1  registered; drives predictor predict_en.
- upd_pc  output  32  registered; drives resolved_pc.
- upd_mispredict  output  1  registered; drives predictionFailed.
- upd_ghist  output  s_history  registered; drives resolved_g_history (the snapshot).
- flush  output  1  registered one-cycle pulse on a mispredict.
- restore_ghist  output  s_history  registered; equals {snapshot[s_history-2:0], res_taken}, valid when flush = 1.
- order_err  output  1  sticky error flag.

Behaviour:
- Storage:
  - Circular buffer with head pointer, tail pointer and count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- Reset (rst = 0 at a posedge):
  - head, tail and count cleared.
  - All registered outputs go to 0, including order_err.
  - Entry contents are don't-care.
  - Reset overrides any same-cycle enq or res, including mid-operation.
- Enqueue:
  - Condition: enq_valid = 1 and count < DEPTH.
  - Writes entry[tail], then tail++ and count++.
  - enq_valid while full is ignored. The entry is dropped and the upstream stage is responsible for the stall.
- Resolve: in cycle N with res_valid = 1 and count > 0, the following happen at the posedge ending N:
  - entry[head] is popped.
  - upd_valid ← 1, upd_pc ← entry.pc, upd_ghist ← entry.ghist.
  - upd_mispredict ← (entry.pred_taken != res_taken).
- Update bundle timing:
  - Visible for exactly cycle N+1. Single-cycle pulse; upd_valid returns to 0 unless a new resolve happens in N+1.
  - Back-to-back resolves give a continuous upd_valid.
- Mispredict in cycle N:
  - flush = 1 during N+1.
  - restore_ghist as defined above.
  - At the same edge the whole queue is cleared (count = 0, head = tail). All younger entries are wrong-path.
  - Any enqueue in cycle N is discarded.
- Correct prediction:
  - flush = 0.
  - A simultaneous enqueue proceeds normally, so count is unchanged.
- Simultaneous enq and res when full: the pop frees a slot, but full is evaluated on the pre-edge count, so the enqueue is still dropped. This is deterministic and required.
- Error cases (each sets order_err):
  - res_valid with count = 0: no update is issued, state is unchanged.
  - res_pc != entry[head].pc: no upd_valid is issued, the entry is popped, and flush is asserted with restore_ghist built from that entry's snapshot.
  - order_err stays set until reset.
- Latency: resolve to predictor update is 1 cycle; resolve to flush is 1 cycle.
- No combinational path from res_* to any output except through registers. full depends only on count.

Test Plan:
- Reset, then enqueue pc = 0x100 (pred 1, ghist 0x05) and pc = 0x104 (pred 0, ghist 0x0A). Resolve 0x100 taken → next cycle upd_valid = 1, upd_pc = 0x100, upd_mispredict = 0, upd_ghist = 0x05, flush = 0, and 1 entry remains.
- Same setup, resolve 0x100 not-taken → next cycle upd_mispredict = 1, flush = 1, restore_ghist = 0x0A (= {0x05[5:0], 0}), and queue empty (a subsequent res_valid sets order_err).
- Fill 4 entries → full = 1. A 5th enq_valid is dropped. Resolve all four in back-to-back cycles, all correct → upd_valid high 4 consecutive cycles with upd_pc in FIFO order; wrap-around is exercised by 4 more enqueues.
- Full queue with enq + correct resolve in the same cycle → enqueue dropped, count = 3. Non-full queue with enq + mispredict in the same cycle → enqueue discarded, count = 0.
- Resolve with res_pc = 0x200 while head pc = 0x100 → upd_valid = 0, flush = 1, order_err = 1 and it stays 1 until reset.
- Assert rst = 0 with 3 entries and a res_valid pending → next cycle every output is 0, and full = 0 after reset.
